score_bcd_display: RTL and testbench

//  Consumes the binary apple-eaten score from the apple placement stage and converts it to BCD.

---
 rtl/score_bcd_display.sv | 187 ++++++++++++++++++
 tb/tb_score_bcd_display.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_display.sv
// Binary score to BCD (iterative double-dabble, one shift per clock) with active-low 7-segment drive.
// Define HIGH_SCORE_EN to add best-score tracking on high_score/new_record; otherwise both are tied to 0.
`timescale 1ns/1ps

module score_bcd_display #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DIGITS     = 5,
    parameter int unsigned BLANK_LEAD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  bcd_valid,
    output logic [WIDTH-1:0]      high_score,
    output logic                  new_record
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned HEX_W = 7 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Walk from the top digit down; digits stay blank while everything above them is zero.
    function automatic logic [HEX_W-1:0] decode(input logic [BCD_W-1:0] b);
        logic [HEX_W-1:0] h;
        logic             lead;
        h    = '0;
        lead = (BLANK_LEAD != 0);
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            if (b[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            h[7*k +: 7] = (lead && k > 0) ? 7'h7F : seg7(b[4*k +: 4]);
        end
        return h;
    endfunction

    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (s[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = s[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    localparam logic [HEX_W-1:0] HEX_RST = decode(BCD_W'(0));

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   latched_q;
    logic [WIDTH-1:0]   last_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [BCD_W-1:0]   adj_c;
    logic               load_c;
    logic               shift_c;
    logic               done_c;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (score != last_q) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            S_IDLE:  load_c  = (score != last_q);
            S_SHIFT: shift_c = 1'b1;
            S_DONE:  done_c  = 1'b1;
            default: ;
        endcase
    end

    assign adj_c = dd_adjust(scratch_q);

    // Conversion datapath; bcd/hex only ever load a finished scratch value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            latched_q <= '0;
            last_q    <= '0;
            scratch_q <= '0;
            bcd       <= '0;
            hex       <= HEX_RST;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (load_c) begin
                latched_q <= score;
                shreg_q   <= score;
                scratch_q <= '0;
                cnt_q     <= '0;
                busy      <= 1'b1;
            end
            if (shift_c) begin
                scratch_q <= {adj_c[BCD_W-2:0], shreg_q[WIDTH-1]};
                shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                cnt_q     <= cnt_q + CNT_W'(1);
            end
            if (done_c) begin
                bcd       <= scratch_q;
                hex       <= decode(scratch_q);
                last_q    <= latched_q;
                bcd_valid <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

`ifdef HIGH_SCORE_EN
    // Best score since reset, updated alongside the display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            new_record <= 1'b0;
            if (done_c && (latched_q > high_score)) begin
                high_score <= latched_q;
                new_record <= 1'b1;
            end
        end
    end
`else
    assign high_score = '0;
    assign new_record = 1'b0;
`endif

endmodule

// File: tb/tb_score_bcd_display.sv
// Randomized scoreboard bench for score_bcd_display against a digit-arithmetic reference model.
`timescale 1ns/1ps

module tb_score_bcd_display;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] score = '0;
    logic [19:0] bcd;
    logic [34:0] hex;
    logic        busy;
    logic        bcd_valid;
    logic [15:0] high_score;
    logic        new_record;

    score_bcd_display dut (
        .clk        (clk),
        .reset      (reset),
        .score      (score),
        .bcd        (bcd),
        .hex        (hex),
        .busy       (busy),
        .bcd_valid  (bcd_valid),
        .high_score (high_score),
        .new_record (new_record)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int rec_pulses = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [19:0] exp_bcd(input int v);
        logic [19:0] b;
        int p;
        b = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            b[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return b;
    endfunction

    // A higher digit is blank exactly when the value is below its place weight
    function automatic logic [34:0] exp_hex(input int v);
        logic [34:0] h;
        int p;
        h = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            h[7*k +: 7] = (k > 0 && v < p) ? 7'h7F : seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion started on an idle edge appears WIDTH+1 edges later
    int m_rem = 0;
    int m_conv = 0;
    int m_last = 0;
    int m_disp = 0;
    int m_high = 0;
    bit m_busy = 1'b0;
    bit m_valid = 1'b0;
    bit m_rec = 1'b0;
    int exp_q[$];

    always @(posedge clk or posedge reset) begin
        m_valid = 1'b0;
        m_rec   = 1'b0;
        if (reset) begin
            m_rem  = 0;
            m_last = 0;
            m_disp = 0;
            m_high = 0;
            exp_q.delete();
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_valid = 1'b1;
                m_disp  = m_conv;
                m_last  = m_conv;
`ifdef HIGH_SCORE_EN
                if (m_conv > m_high) begin
                    m_high = m_conv;
                    m_rec  = 1'b1;
                end
`endif
                exp_q.push_back(m_conv);
            end
        end else if (int'(score) != m_last) begin
            m_conv = int'(score);
            m_rem  = WIDTH + 1;
        end
        m_busy = (m_rem > 0);
    end

    // Monitor: sampled mid-cycle, pops the scoreboard whenever the DUT flags a result
    always @(negedge clk) begin
        int v;
        chk("busy", 64'(busy), 64'(m_busy));
        chk("bcd_valid", 64'(bcd_valid), 64'(m_valid));
        chk("new_record", 64'(new_record), 64'(m_rec));
        chk("high_score", 64'(high_score), 64'(m_high));
        chk("bcd_hold", 64'(bcd), 64'(exp_bcd(m_disp)));
        chk("hex_hold", 64'(hex), 64'(exp_hex(m_disp)));
        if (bcd_valid === 1'b1) begin
            pulses++;
            if (new_record === 1'b1) rec_pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: bcd_valid with bcd=%0h but no result expected at %0t", bcd, $time);
            end else begin
                v = exp_q.pop_front();
                chk("sb_bcd", 64'(bcd), 64'(exp_bcd(v)));
                chk("sb_hex", 64'(hex), 64'(exp_hex(v)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (m_rem == 0 && int'(score) == m_last) done = 1'b1;
            step();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wait_idle: conversion of %0d still pending after 200 cycles", score);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r0;
        int pick;

        reset = 1'b1;
        score = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();
        chk("reset_bcd", 64'(bcd), 64'h0);
        chk("reset_hex", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("reset_busy", 64'(busy), 64'h0);

        score = 16'd1;
        wait_idle();
        chk("one_bcd", 64'(bcd), 64'h00001);
        score = 16'd9999;
        wait_idle();
        chk("9999_bcd", 64'(bcd), 64'h09999);
        chk("9999_top_blank", 64'(hex[34:28]), 64'h7F);

        score = 16'd65535;
        wait_idle();
        chk("65535_bcd", 64'(bcd), 64'h65535);
        score = 16'd10;
        wait_idle();
        chk("10_bcd", 64'(bcd), 64'h00010);
        chk("10_units", 64'(hex[6:0]), 64'h40);
        chk("10_tens", 64'(hex[13:7]), 64'h79);

        p0 = pulses;
        score = 16'd5;
        repeat (4) step();
        score = 16'd6;
        wait_idle();
        chk("two_pulses", 64'(pulses - p0), 64'd2);
        chk("6_bcd", 64'(bcd), 64'h00006);

        score = 16'd1234;
        repeat (9) step();
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_bcd", 64'(bcd), 64'h0);
        score = 16'd7;
        step();
        step();
        reset = 1'b0;
        wait_idle();
        chk("7_bcd", 64'(bcd), 64'h00007);

        r0 = rec_pulses;
        score = 16'd12;
        wait_idle();
`ifdef HIGH_SCORE_EN
        chk("hs_12", 64'(high_score), 64'd12);
`else
        chk("hs_12", 64'(high_score), 64'd0);
`endif
        score = 16'd30;
        wait_idle();
`ifdef HIGH_SCORE_EN
        chk("hs_30", 64'(high_score), 64'd30);
`else
        chk("hs_30", 64'(high_score), 64'd0);
`endif
        score = 16'd20;
        wait_idle();
`ifdef HIGH_SCORE_EN
        chk("hs_20", 64'(high_score), 64'd30);
        chk("record_pulses", 64'(rec_pulses - r0), 64'd2);
`else
        chk("hs_20", 64'(high_score), 64'd0);
        chk("record_pulses", 64'(rec_pulses - r0), 64'd0);
`endif

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: pick = int'($urandom_range(0, 65535));
                1: pick = int'($urandom_range(0, 99));
                2: begin
                    case ($urandom_range(0, 7))
                        0: pick = 0;
                        1: pick = 65535;
                        2: pick = 9;
                        3: pick = 99;
                        4: pick = 100;
                        5: pick = 999;
                        6: pick = 10000;
                        default: pick = 9999;
                    endcase
                end
                default: pick = int'(score) + 1;
            endcase
            score = 16'(pick);
            repeat ($urandom_range(1, 22)) step();
        end
        wait_idle();
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
